// File: rtl/ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ifetch_unit                                                |
// | Description : miniRV instruction fetch stage. Holds the PC, issues one   |
// |               outstanding request at a time to instruction memory,       |
// |               registers fetched words into the IF/ID slot and forms      |
// |               branch / jal / jalr targets from execute-stage operands.   |
// | Ports       : cpu_clk, cpu_rst_n (async assert, active-low)              |
// |               imem_req/imem_addr/imem_ack/imem_rdata : memory handshake  |
// |               ex_valid/npc_op/br_taken/ex_pc/ex_rs1/ex_imm : redirect in |
// |               id_ready/id_valid/id_inst/id_pc/id_pc4/id_imm_din : slot   |
// |               redirect : combinational redirect-taken flag               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        ex_valid,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_imm,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [24:0] id_imm_din,
    output logic        redirect
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WAIT    = 2'd1;
    localparam logic [1:0] c_HOLD    = 2'd2;
    localparam logic [1:0] c_DISCARD = 2'd3;

    localparam logic [1:0] c_OP_BRANCH = 2'b01;
    localparam logic [1:0] c_OP_JAL    = 2'b10;
    localparam logic [1:0] c_OP_JALR   = 2'b11;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_skid_valid;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_id_valid;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc;

    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_redirect;
    logic        w_slot_free;
    logic        w_load_mem;
    logic        w_load_skid;

    // ------------------------------------------------------------------
    // Redirect decode and target formation
    // ------------------------------------------------------------------
    always_comb begin
        w_redirect = ex_valid & ((npc_op == c_OP_JAL) | (npc_op == c_OP_JALR) |
                                 ((npc_op == c_OP_BRANCH) & br_taken));
        if (npc_op == c_OP_JALR) begin
            w_target = (ex_rs1 + ex_imm) & ~32'h1;
        end else begin
            w_target = ex_pc + ex_imm;
        end
    end

    assign w_pc_plus4 = r_pc + 32'd4;
    // In DISCARD a redirect coinciding with the ack must win over the
    // previously latched target, otherwise the newest target would be lost.
    assign w_pc_next  = w_redirect ? w_target : r_pc;

    // The slot can take a new word if it is empty or decode consumes it now.
    assign w_slot_free = ~r_id_valid | id_ready;
    assign w_load_mem  = (r_state == c_WAIT) & imem_ack & ~w_redirect & w_slot_free;
    assign w_load_skid = (r_state == c_HOLD) & ~w_redirect & id_ready & r_skid_valid;

    // ------------------------------------------------------------------
    // Fetch FSM: pc, request address and skid register
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state      <= c_IDLE;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= NOP_INST;
            r_skid_pc    <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // imem_ack is deliberately not sampled here so that a
                    // response left over from before reset is ignored.
                    r_req_addr <= r_pc;
                    r_state    <= c_WAIT;
                end
                c_WAIT: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        if (imem_ack) begin
                            r_req_addr <= w_target;
                        end else begin
                            // Request must stay stable until its ack arrives.
                            r_state <= c_DISCARD;
                        end
                    end else if (imem_ack) begin
                        r_pc <= w_pc_plus4;
                        if (w_slot_free) begin
                            r_req_addr <= w_pc_plus4;
                        end else begin
                            r_skid_valid <= 1'b1;
                            r_skid_inst  <= imem_rdata;
                            r_skid_pc    <= r_req_addr;
                            r_state      <= c_HOLD;
                        end
                    end
                end
                c_HOLD: begin
                    if (w_redirect) begin
                        r_skid_valid <= 1'b0;
                        r_pc         <= w_target;
                        r_req_addr   <= w_target;
                        r_state      <= c_WAIT;
                    end else if (id_ready) begin
                        r_skid_valid <= 1'b0;
                        r_req_addr   <= r_pc;
                        r_state      <= c_WAIT;
                    end
                end
                c_DISCARD: begin
                    r_pc <= w_pc_next;
                    if (imem_ack) begin
                        r_req_addr <= w_pc_next;
                        r_state    <= c_WAIT;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IF/ID output slot; flush has priority over any load
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP_INST;
            r_id_pc    <= 32'd0;
        end else if (w_redirect) begin
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP_INST;
        end else if (w_load_mem) begin
            r_id_valid <= 1'b1;
            r_id_inst  <= imem_rdata;
            r_id_pc    <= r_req_addr;
        end else if (w_load_skid) begin
            r_id_valid <= 1'b1;
            r_id_inst  <= r_skid_inst;
            r_id_pc    <= r_skid_pc;
        end else if (id_ready) begin
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP_INST;
        end
    end

    assign imem_req   = (r_state == c_WAIT) | (r_state == c_DISCARD);
    assign imem_addr  = r_req_addr;
    assign id_valid   = r_id_valid;
    assign id_inst    = r_id_inst;
    assign id_pc      = r_id_pc;
    assign id_pc4     = r_id_pc + 32'd4;
    assign id_imm_din = r_id_inst[31:7];
    assign redirect   = w_redirect;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ifetch_unit                                             |
// | Description : Directed self-checking bench for ifetch_unit with a        |
// |               memory model returning addr ^ 32'hA5A5_0000 and a          |
// |               scoreboard of expected (inst, pc) slot contents.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ifetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [31:0] c_XOR      = 32'hA5A5_0000;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ex_valid;
    logic [1:0]  npc_op;
    logic        br_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1;
    logic [31:0] ex_imm;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [24:0] id_imm_din;
    logic        redirect;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    // Memory model controls
    int    mem_cnt;
    int    mem_delay = 0;
    logic  mem_en    = 1'b1;
    logic  force_ack = 1'b0;

    ifetch_unit #(
        .RESET_PC (c_RESET_PC),
        .NOP_INST (c_NOP)
    ) u_dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst_n  (cpu_rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ex_valid   (ex_valid),
        .npc_op     (npc_op),
        .br_taken   (br_taken),
        .ex_pc      (ex_pc),
        .ex_rs1     (ex_rs1),
        .ex_imm     (ex_imm),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_pc4     (id_pc4),
        .id_imm_din (id_imm_din),
        .redirect   (redirect)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    // Memory: acks after mem_delay waiting cycles; force_ack injects a stray ack.
    always @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            mem_cnt <= 0;
        end else if (imem_req && !imem_ack) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end

    assign imem_ack   = force_ack | (imem_req & mem_en & (mem_cnt >= mem_delay));
    assign imem_rdata = imem_addr ^ c_XOR;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr);
        item_t it;
        it.inst = addr ^ c_XOR;
        it.pc   = addr;
        sb.push_back(it);
    endtask

    // Scoreboard: every word consumed by decode must match the next expected one.
    always @(negedge cpu_clk) begin
        item_t it;
        if (cpu_rst_n && id_valid && id_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL sb_unexpected: observed inst=%h pc=%h expected none", id_inst, id_pc);
            end else begin
                it = sb.pop_front();
                chk("sb_inst", id_inst, it.inst);
                chk("sb_pc", id_pc, it.pc);
                chk("sb_pc4", id_pc4, it.pc + 32'd4);
                chk("sb_imm_din", {7'd0, id_imm_din}, {7'd0, it.inst[31:7]});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cpu_rst_n = 1'b0;
        ex_valid  = 1'b0;
        npc_op    = 2'b00;
        br_taken  = 1'b0;
        ex_pc     = 32'd0;
        ex_rs1    = 32'd0;
        ex_imm    = 32'd0;
        id_ready  = 1'b1;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", id_valid, 0);
        chk("rst_inst", id_inst, c_NOP);
        chk("rst_pc", id_pc, 0);
        chk("rst_pc4", id_pc4, 4);
        chk("rst_addr", imem_addr, c_RESET_PC);
        chk("rst_redirect", redirect, 0);

        // ---------------- zero-wait streaming ----------------
        for (int i = 0; i < 5; i++) push(32'(i * 4));
        cpu_rst_n = 1'b1;
        chk("idle_req", imem_req, 0);
        step();                                   // IDLE -> WAIT
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        chk("first_valid", id_valid, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stream_valid", id_valid, 1);
        end
        step();                                   // slot now holds pc 20
        id_ready = 1'b0;
        mem_en   = 1'b0;
        chk("stream_pc20", id_pc, 32'd20);

        // ---------------- reset pulse mid-WAIT ----------------
        step();
        chk("pre_rst_req", imem_req, 1);
        chk("pre_rst_addr", imem_addr, 32'd24);
        chk("pre_rst_valid", id_valid, 1);
        #3;
        cpu_rst_n = 1'b0;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_valid", id_valid, 0);
        chk("async_inst", id_inst, c_NOP);
        chk("async_addr", imem_addr, c_RESET_PC);
        step();
        cpu_rst_n = 1'b1;
        force_ack = 1'b1;                         // stray ack while in IDLE
        chk("rel_req", imem_req, 0);
        step();
        force_ack = 1'b0;
        mem_en    = 1'b1;
        id_ready  = 1'b1;
        chk("refetch_req", imem_req, 1);
        chk("refetch_addr", imem_addr, c_RESET_PC);
        chk("refetch_valid", id_valid, 0);

        // ---------------- decode stall into skid ----------------
        push(32'd0);
        push(32'd4);
        push(32'd8);
        step();                                   // slot pc 0
        id_ready = 1'b0;
        chk("stall_valid", id_valid, 1);
        chk("stall_pc0", id_pc, 0);
        step();                                   // pc 4 -> skid, HOLD
        chk("hold_req", imem_req, 0);
        chk("hold_pc0", id_pc, 0);
        step();
        chk("hold_req2", imem_req, 0);
        step();
        id_ready = 1'b1;
        chk("hold_req3", imem_req, 0);
        chk("hold_pc0b", id_pc, 0);
        step();                                   // skid -> slot
        chk("skid_pc4", id_pc, 32'd4);
        chk("skid_req", imem_req, 1);
        chk("skid_addr", imem_addr, 32'd8);
        step();                                   // slot pc 8

        // ---------------- jal redirect ----------------
        ex_valid = 1'b1;
        npc_op   = 2'b10;
        ex_pc    = 32'h0000_0100;
        ex_imm   = 32'hFFFF_FFF0;
        #1;
        chk("jal_redirect", redirect, 1);
        push(32'h0000_00F0);
        step();
        ex_valid = 1'b0;
        #1;
        chk("jal_flush", id_valid, 0);
        chk("jal_addr", imem_addr, 32'h0000_00F0);
        chk("jal_req", imem_req, 1);
        chk("jal_redirect_off", redirect, 0);
        step();                                   // slot pc F0

        // ---------------- jalr redirect ----------------
        ex_valid = 1'b1;
        npc_op   = 2'b11;
        ex_rs1   = 32'h0000_0203;
        ex_imm   = 32'h0000_0004;
        #1;
        chk("jalr_redirect", redirect, 1);
        push(32'h0000_0206);
        step();
        npc_op   = 2'b01;
        br_taken = 1'b0;
        #1;
        chk("br_nt_redirect", redirect, 0);
        chk("jalr_addr", imem_addr, 32'h0000_0206);
        chk("jalr_flush", id_valid, 0);
        step();                                   // slot pc 206
        chk("br_nt_addr", imem_addr, 32'h0000_020A);

        // ---------------- redirect during slow memory ----------------
        mem_delay = 3;
        npc_op    = 2'b10;
        ex_pc     = 32'h0000_0300;
        ex_imm    = 32'h0000_0010;
        #1;
        chk("slow_redirect", redirect, 1);
        chk("slow_no_ack", imem_ack, 0);
        push(32'h0000_0310);
        step();                                   // WAIT -> DISCARD
        ex_valid = 1'b0;
        chk("disc_req", imem_req, 1);
        chk("disc_addr", imem_addr, 32'h0000_020A);
        chk("disc_flush", id_valid, 0);
        step();
        chk("disc_addr2", imem_addr, 32'h0000_020A);
        step();
        chk("disc_addr3", imem_addr, 32'h0000_020A);
        chk("disc_ack", imem_ack, 1);
        step();
        chk("tgt_addr", imem_addr, 32'h0000_0310);
        chk("tgt_req", imem_req, 1);
        chk("stale_valid", id_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tgt_wait_valid", id_valid, 0);
            chk("tgt_wait_addr", imem_addr, 32'h0000_0310);
        end
        step();                                   // slot pc 310
        mem_en = 1'b0;
        chk("tgt_valid", id_valid, 1);
        step();
        chk("drain_valid", id_valid, 0);
        chk("drain_inst", id_inst, c_NOP);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
